// File: rtl/bc_pkg.sv
// rtl/bc_pkg.sv - shared constants and helpers for the bc_sequencer control unit
// Purpose: sequencer state encodings, control-word geometry helpers, field
//          offsets and the default five-step control program.
// Ports:   none (package).
package bc_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_RUN    = 2'd1;
  localparam state_t S_FINISH = 2'd2;

  // Control word = {load, h, mux[N_MUX-1], ..., mux[0]}, LSB first.
  function automatic int cw_width(input int n_load, input int n_mux, input int mux_w);
    return n_load + 1 + n_mux * mux_w;
  endfunction

  function automatic int h_offset(input int n_mux, input int mux_w);
    return n_mux * mux_w;
  endfunction

  function automatic int load_offset(input int n_mux, input int mux_w);
    return n_mux * mux_w + 1;
  endfunction

  localparam int DEF_N_STEPS  = 5;
  localparam int DEF_N_MUX    = 3;
  localparam int DEF_MUX_W    = 2;
  localparam int DEF_N_LOAD   = 3;
  localparam int DEF_CW       = cw_width(DEF_N_LOAD, DEF_N_MUX, DEF_MUX_W);
  localparam int MUX_OFS      = 0;
  localparam int DEF_H_OFS    = h_offset(DEF_N_MUX, DEF_MUX_W);
  localparam int DEF_LOAD_OFS = load_offset(DEF_N_MUX, DEF_MUX_W);

  // Per word: load[2:0] (bit0=LX, bit1=LS, bit2=LH), h, m2, m1, m0.
  localparam logic [DEF_N_STEPS*DEF_CW-1:0] DEF_STEP_TABLE = {
    10'b010_0_10_00_11,   // step 4: mux {2,0,3}, load LS,    h=0
    10'b011_1_00_00_10,   // step 3: mux {0,0,2}, load LX+LS, h=1
    10'b100_1_11_11_01,   // step 2: mux {3,3,1}, load LH,    h=1
    10'b001_0_01_10_11,   // step 1: mux {1,2,3}, load LX,    h=0
    10'b101_1_00_01_00    // step 0: mux {0,1,0}, load LX+LH, h=1
  };

endpackage

// File: rtl/bc_step_rom.sv
// rtl/bc_step_rom.sv - combinational step index to control-word field lookup
// Purpose: selects one control word out of the packed step table and splits
//          it into mux selects, flag and load enables.
// Ports:   i_idx     step index (values >= N_STEPS yield an all-zero word)
//          o_mux_sel concatenated mux selects, mux0 in the low bits
//          o_h       flag bit
//          o_load    register load enables
module bc_step_rom
  import bc_pkg::*;
#(
  parameter int N_STEPS = DEF_N_STEPS,
  parameter int N_MUX   = DEF_N_MUX,
  parameter int MUX_W   = DEF_MUX_W,
  parameter int N_LOAD  = DEF_N_LOAD,
  parameter int IDX_W   = 3,
  parameter logic [N_STEPS*cw_width(N_LOAD, N_MUX, MUX_W)-1:0] STEP_TABLE = DEF_STEP_TABLE
) (
  input  logic [IDX_W-1:0]       i_idx,
  output logic [N_MUX*MUX_W-1:0] o_mux_sel,
  output logic                   o_h,
  output logic [N_LOAD-1:0]      o_load
);

  localparam int CW       = cw_width(N_LOAD, N_MUX, MUX_W);
  localparam int H_OFS    = h_offset(N_MUX, MUX_W);
  localparam int LOAD_OFS = load_offset(N_MUX, MUX_W);

  logic [CW-1:0] w_word;

  // Compare-and-select keeps every part-select constant, so an index past
  // the table can never address bits outside STEP_TABLE.
  always_comb begin
    w_word = '0;
    for (int i = 0; i < N_STEPS; i++) begin
      if (i_idx == IDX_W'(i)) begin
        w_word = STEP_TABLE[i*CW +: CW];
      end
    end
  end

  assign o_mux_sel = w_word[MUX_OFS +: N_MUX*MUX_W];
  assign o_h       = w_word[H_OFS];
  assign o_load    = w_word[LOAD_OFS +: N_LOAD];

endmodule

// File: rtl/bc_sequencer.sv
// rtl/bc_sequencer.sv - table-driven datapath control sequencer with loop count and stall
// Purpose: plays the step program out of STEP_TABLE, repeating it a latched
//          number of times, and owns every datapath control signal.
// Ports:   clk, reset   clock, synchronous active-high reset
//          i_inicio     start request, honoured in IDLE only
//          i_loops      program repetitions, 0 behaves as 1
//          i_stall      datapath not ready, freezes the step counter
//          o_busy       high while running the program
//          o_done       one-cycle pulse after the final step
//          o_mux_sel    concatenated mux selects
//          o_load       register load enables
//          o_h          flag bit of the presented step
module bc_sequencer
  import bc_pkg::*;
#(
  parameter int N_STEPS = DEF_N_STEPS,
  parameter int N_MUX   = DEF_N_MUX,
  parameter int MUX_W   = DEF_MUX_W,
  parameter int N_LOAD  = DEF_N_LOAD,
  parameter int LOOP_W  = 4,
  parameter logic [N_STEPS*cw_width(N_LOAD, N_MUX, MUX_W)-1:0] STEP_TABLE = DEF_STEP_TABLE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_inicio,
  input  logic [LOOP_W-1:0]      i_loops,
  input  logic                   i_stall,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [N_MUX*MUX_W-1:0] o_mux_sel,
  output logic [N_LOAD-1:0]      o_load,
  output logic                   o_h
);

  localparam int IDX_W = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;

  state_t                   r_state;
  logic [IDX_W-1:0]         r_step;
  // One bit wider than i_loops so the count can pass the maximum without wrapping.
  logic [LOOP_W:0]          r_loop;
  logic [LOOP_W:0]          r_loops;
  logic                     r_busy;
  logic                     r_done;
  logic [N_MUX*MUX_W-1:0]   r_mux_sel;
  logic [N_LOAD-1:0]        r_load;
  logic                     r_h;

  logic                     w_last_step;
  logic                     w_last_loop;
  logic [IDX_W-1:0]         w_next_step;
  logic [N_MUX*MUX_W-1:0]   w_rom_mux;
  logic                     w_rom_h;
  logic [N_LOAD-1:0]        w_rom_load;

  assign w_last_step = (r_step == IDX_W'(N_STEPS - 1));
  assign w_last_loop = (r_loop == r_loops);

  // The ROM is addressed with the step about to be presented, so the output
  // registers load the new word on the same edge the counter advances.
  always_comb begin
    w_next_step = '0;
    if (r_state == S_RUN && !w_last_step) begin
      w_next_step = r_step + IDX_W'(1);
    end
  end

  bc_step_rom #(
    .N_STEPS    (N_STEPS),
    .N_MUX      (N_MUX),
    .MUX_W      (MUX_W),
    .N_LOAD     (N_LOAD),
    .IDX_W      (IDX_W),
    .STEP_TABLE (STEP_TABLE)
  ) u_rom (
    .i_idx     (w_next_step),
    .o_mux_sel (w_rom_mux),
    .o_h       (w_rom_h),
    .o_load    (w_rom_load)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_step    <= '0;
      r_loop    <= '0;
      r_loops   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_mux_sel <= '0;
      r_load    <= '0;
      r_h       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_inicio) begin
            r_state   <= S_RUN;
            r_loops   <= (i_loops == '0) ? (LOOP_W+1)'(1) : {1'b0, i_loops};
            r_step    <= '0;
            r_loop    <= (LOOP_W+1)'(1);
            r_busy    <= 1'b1;
            r_mux_sel <= w_rom_mux;
            r_load    <= w_rom_load;
            r_h       <= w_rom_h;
          end else begin
            r_busy    <= 1'b0;
            r_mux_sel <= '0;
            r_load    <= '0;
            r_h       <= 1'b0;
          end
        end
        S_RUN: begin
          if (i_stall) begin
            // Hold mux/h so the datapath sees a stable word; drop load so
            // the current step's registers are written only once.
            r_load <= '0;
          end else if (w_last_step && w_last_loop) begin
            r_state   <= S_FINISH;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_mux_sel <= '0;
            r_load    <= '0;
            r_h       <= 1'b0;
          end else begin
            r_step    <= w_next_step;
            if (w_last_step) begin
              r_loop <= r_loop + (LOOP_W+1)'(1);
            end
            r_mux_sel <= w_rom_mux;
            r_load    <= w_rom_load;
            r_h       <= w_rom_h;
          end
        end
        S_FINISH: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_step  <= '0;
          r_loop  <= '0;
        end
        default: begin
          r_state   <= S_IDLE;
          r_busy    <= 1'b0;
          r_done    <= 1'b0;
          r_mux_sel <= '0;
          r_load    <= '0;
          r_h       <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_mux_sel = r_mux_sel;
  assign o_load    = r_load;
  assign o_h       = r_h;

endmodule
